// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the fetch/data memory port arbiter.
package mem_arb_pkg;

    localparam int MEM_ARB_ADDR_W     = 32;
    localparam int MEM_ARB_DATA_W     = 32;
    localparam int MEM_ARB_MAX_STREAK = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
    typedef enum logic {OWN_IF, OWN_DM} owner_e;

endpackage

// File: rtl/mem_arb_select.sv
// Winner select between fetch and data requests. With MEM_ARB_STARVE_GUARD_EN defined,
// a streak counter forces a fetch grant after MAX_STREAK data grants taken while fetch waited.
module mem_arb_select import mem_arb_pkg::*; #(
    parameter int MAX_STREAK = MEM_ARB_MAX_STREAK
) (
`ifdef MEM_ARB_STARVE_GUARD_EN
    input  logic clk,
    input  logic reset_n,
`endif
    input  logic en_i,
    input  logic if_req_i,
    input  logic dm_req_i,
    output logic gnt_if_o,
    output logic gnt_dm_o
);

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int STREAK_W = $clog2(MAX_STREAK + 1);

    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                starve;

    assign starve   = (streak_q == STREAK_W'(MAX_STREAK));
    assign gnt_dm_o = en_i && dm_req_i && !(starve && if_req_i);
    assign gnt_if_o = en_i && if_req_i && !gnt_dm_o;

    // Idle cycles without a fetch request also clear, so only a contiguous starvation counts.
    always_comb begin
        streak_d = streak_q;
        if (gnt_if_o || (en_i && !if_req_i))
            streak_d = '0;
        else if (gnt_dm_o && if_req_i && !starve)
            streak_d = streak_q + STREAK_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            streak_q <= '0;
        else
            streak_q <= streak_d;
    end
`else
    assign gnt_dm_o = en_i && dm_req_i;
    assign gnt_if_o = en_i && if_req_i && !dm_req_i;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data requesters, one transaction at a time.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter import mem_arb_pkg::*; #(
    parameter int ADDR_W     = MEM_ARB_ADDR_W,
    parameter int DATA_W     = MEM_ARB_DATA_W,
    parameter int MAX_STREAK = MEM_ARB_MAX_STREAK
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ready,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic                dm_ready,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int BE_W = DATA_W / 8;

    arb_state_e          state_q;
    owner_e              owner_q;
    logic                mem_req_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BE_W-1:0]     be_q;
    logic                if_rvalid_q, dm_rvalid_q;
    logic [DATA_W-1:0]   if_rdata_q, dm_rdata_q;

    logic arb_en, gnt_if, gnt_dm, resp_take;

    // Gating with reset_n keeps a request from being acknowledged during reset.
    assign arb_en = reset_n && (state_q == IDLE);

    mem_arb_select #(.MAX_STREAK(MAX_STREAK)) u_select (
`ifdef MEM_ARB_STARVE_GUARD_EN
        .clk      (clk),
        .reset_n  (reset_n),
`endif
        .en_i     (arb_en),
        .if_req_i (if_req),
        .dm_req_i (dm_req),
        .gnt_if_o (gnt_if),
        .gnt_dm_o (gnt_dm)
    );

    assign resp_take = mem_rvalid && ((state_q == WAIT) || (state_q == ISSUE && mem_gnt));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            mem_req_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (gnt_if || gnt_dm) begin
                        state_q   <= ISSUE;
                        mem_req_q <= 1'b1;
                        owner_q   <= gnt_dm ? OWN_DM : OWN_IF;
                        addr_q    <= gnt_dm ? dm_addr : if_addr;
                        we_q      <= gnt_dm && dm_we;
                        wdata_q   <= gnt_dm ? dm_wdata : '0;
                        be_q      <= gnt_dm ? dm_be : '1;
                    end
                end
                ISSUE: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= mem_rvalid ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid)
                        state_q <= RESP;
                end
                RESP: begin
                    state_q     <= IDLE;
                    if_rvalid_q <= 1'b0;
                    dm_rvalid_q <= 1'b0;
                    if_rdata_q  <= '0;
                    dm_rdata_q  <= '0;
                end
                default: state_q <= IDLE;
            endcase

            if (resp_take) begin
                if (owner_q == OWN_DM) begin
                    dm_rvalid_q <= 1'b1;
                    dm_rdata_q  <= we_q ? '0 : mem_rdata;
                end else begin
                    if_rvalid_q <= 1'b1;
                    if_rdata_q  <= mem_rdata;
                end
            end
        end
    end

    assign if_ready  = gnt_if;
    assign dm_ready  = gnt_dm;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rvalid = dm_rvalid_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter; expectations for the starvation pattern follow
// whether MEM_ARB_STARVE_GUARD_EN is defined.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ready, if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] dm_addr = '0, dm_wdata = '0;
    logic [3:0]  dm_be = '0;
    logic        dm_ready, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
        .dm_ready(dm_ready), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
    );

    typedef struct packed { logic dm; logic [31:0] data; } exp_t;
    exp_t sb_q[$];
    int n_checks = 0;
    int n_fail = 0;

    // Memory model: grant after gnt_delay cycles of mem_req, respond the following cycle.
    bit          auto_mem = 1'b0;
    int          gnt_delay = 0;
    int          wait_cnt = 0;
    bit          rsp_pend = 1'b0;
    logic [31:0] rsp_addr = '0;
    logic        rsp_we = 1'b0;

    function automatic logic [31:0] model_rd(logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    always @(posedge clk) begin
        #1;
        if (auto_mem) begin
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (rsp_pend) begin
                mem_rvalid = 1'b1;
                mem_rdata = rsp_we ? 32'h0BAD_0BAD : model_rd(rsp_addr);
                rsp_pend = 1'b0;
            end else if (mem_req) begin
                if (wait_cnt < gnt_delay) wait_cnt++;
                else begin
                    mem_gnt = 1'b1; rsp_pend = 1'b1; rsp_addr = mem_addr; rsp_we = mem_we; wait_cnt = 0;
                end
            end
        end
    end

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if ({busy, mem_req, mem_we, if_ready, dm_ready, if_rvalid, dm_rvalid} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0000000", {busy, mem_req, mem_we, if_ready, dm_ready, if_rvalid, dm_rvalid}); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
        n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", mem_wdata); end
        n_checks++; if (mem_be !== 4'h0) begin n_fail++; $display("FAIL reset_be: got %h expected 0", mem_be); end
        n_checks++; if ({if_rdata, dm_rdata} !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h %h expected 0 0", if_rdata, dm_rdata); end
        @(posedge clk); #1; reset_n = 1'b1;
    endtask

    task automatic test_single_fetch();
        exp_t e;
        auto_mem = 1'b0;
        @(posedge clk); #1; if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        n_checks++; if ({if_ready, dm_ready, busy} !== 3'b100) begin n_fail++; $display("FAIL fetch_ready_T: got %b expected 100", {if_ready, dm_ready, busy}); end
        sb_q.push_back('{dm: 1'b0, data: 32'hDEADBEEF});
        @(posedge clk); #1; if_req = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        n_checks++; if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
            n_fail++; $display("FAIL fetch_issue: got req=%b we=%b be=%h addr=%h expected 1 0 f 00000100", mem_req, mem_we, mem_be, mem_addr); end
        @(posedge clk); #1; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        n_checks++; if ({if_rvalid, mem_req} !== 2'b00) begin n_fail++; $display("FAIL fetch_T2: got %b expected 00", {if_rvalid, mem_req}); end
        @(posedge clk); #1; mem_rvalid = 1'b0; mem_rdata = '0;
        @(negedge clk);
        n_checks++;
        if (sb_q.size() == 0) begin n_fail++; $display("FAIL fetch_sb: scoreboard empty"); end
        else begin
            e = sb_q.pop_front();
            if (if_rvalid !== 1'b1 || dm_rvalid !== 1'b0 || if_rdata !== e.data || dm_rdata !== 32'h0) begin
                n_fail++; $display("FAIL fetch_rvalid_T3: got ifv=%b dmv=%b data=%h expected 1 0 %h", if_rvalid, dm_rvalid, if_rdata, e.data); end
        end
        @(negedge clk);
        n_checks++; if ({if_rvalid, busy} !== 2'b00) begin n_fail++; $display("FAIL fetch_after: got %b expected 00", {if_rvalid, busy}); end
    endtask

    task automatic test_priority();
        exp_t e;
        bit got;
        auto_mem = 1'b1; gnt_delay = 0;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h300;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hCAFE0001; dm_be = 4'h3;
        @(negedge clk);
        n_checks++; if ({if_ready, dm_ready} !== 2'b01) begin n_fail++; $display("FAIL prio_winner: got if/dm=%b expected 01", {if_ready, dm_ready}); end
        sb_q.push_back('{dm: 1'b1, data: 32'h0});
        @(posedge clk); #1; dm_req = 1'b0; dm_we = 1'b0;
        @(negedge clk);
        n_checks++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_ready} !== {1'b1, 1'b1, 4'h3, 32'h200, 32'hCAFE0001, 1'b0}) begin
            n_fail++; $display("FAIL prio_store_issue: got req=%b we=%b be=%h addr=%h wd=%h ifr=%b expected 1 1 3 00000200 cafe0001 0",
                                mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_ready); end
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin @(negedge clk); if (if_rvalid || dm_rvalid) begin got = 1'b1; break; end end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL prio_store_resp: no rvalid within 10 cycles"); end
        else if (sb_q.size() == 0) begin n_fail++; $display("FAIL prio_store_sb: scoreboard empty"); end
        else begin
            e = sb_q.pop_front();
            if (dm_rvalid !== e.dm || if_rvalid !== 1'b0 || dm_rdata !== e.data || if_rdata !== 32'h0) begin
                n_fail++; $display("FAIL prio_store_resp: got dmv=%b ifv=%b dmd=%h expected 1 0 %h", dm_rvalid, if_rvalid, dm_rdata, e.data); end
        end
        @(negedge clk);
        n_checks++; if ({if_ready, dm_ready} !== 2'b10) begin n_fail++; $display("FAIL prio_fetch_next: got if/dm=%b expected 10", {if_ready, dm_ready}); end
        sb_q.push_back('{dm: 1'b0, data: model_rd(32'h300)});
        @(posedge clk); #1; if_req = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin @(negedge clk); if (if_rvalid || dm_rvalid) begin got = 1'b1; break; end end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL prio_fetch_resp: no rvalid within 10 cycles"); end
        else if (sb_q.size() == 0) begin n_fail++; $display("FAIL prio_fetch_sb: scoreboard empty"); end
        else begin
            e = sb_q.pop_front();
            if (if_rvalid !== 1'b1 || dm_rvalid !== 1'b0 || if_rdata !== e.data) begin
                n_fail++; $display("FAIL prio_fetch_resp: got ifv=%b dmv=%b data=%h expected 1 0 %h", if_rvalid, dm_rvalid, if_rdata, e.data); end
        end
    endtask

    task automatic test_gnt_stall();
        exp_t e;
        bit got;
        auto_mem = 1'b1; gnt_delay = 5;
        @(posedge clk); #1; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h440; dm_wdata = 32'h1111_2222; dm_be = 4'hF;
        @(negedge clk);
        n_checks++; if (dm_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready: got %b expected 1", dm_ready); end
        sb_q.push_back('{dm: 1'b1, data: model_rd(32'h440)});
        @(posedge clk); #1; dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h480;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++; if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 32'h440, 32'h1111_2222}) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got req=%b addr=%h wd=%h expected 1 00000440 11112222", c, mem_req, mem_addr, mem_wdata); end
            n_checks++; if ({if_ready, dm_ready, if_rvalid, dm_rvalid} !== 4'b0) begin
                n_fail++; $display("FAIL stall_pulse[%0d]: got %b expected 0000", c, {if_ready, dm_ready, if_rvalid, dm_rvalid}); end
        end
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin @(negedge clk); if (if_rvalid || dm_rvalid) begin got = 1'b1; break; end end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL stall_resp: no rvalid within 10 cycles"); end
        else if (sb_q.size() == 0) begin n_fail++; $display("FAIL stall_sb: scoreboard empty"); end
        else begin
            e = sb_q.pop_front();
            if (dm_rvalid !== e.dm || if_rvalid !== 1'b0 || dm_rdata !== e.data) begin
                n_fail++; $display("FAIL stall_resp: got dmv=%b ifv=%b data=%h expected 1 0 %h", dm_rvalid, if_rvalid, dm_rdata, e.data); end
        end
        @(negedge clk);
        n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL stall_fetch_ready: got %b expected 1", if_ready); end
        sb_q.push_back('{dm: 1'b0, data: model_rd(32'h480)});
        @(posedge clk); #1; if_req = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin @(negedge clk); if (if_rvalid || dm_rvalid) begin got = 1'b1; break; end end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL stall_fetch_resp: no rvalid within 20 cycles"); end
        else if (sb_q.size() == 0) begin n_fail++; $display("FAIL stall_fetch_sb: scoreboard empty"); end
        else begin
            e = sb_q.pop_front();
            if (if_rvalid !== 1'b1 || if_rdata !== e.data) begin
                n_fail++; $display("FAIL stall_fetch_resp: got ifv=%b data=%h expected 1 %h", if_rvalid, if_rdata, e.data); end
        end
        gnt_delay = 0;
    endtask

    task automatic test_reset_midflight();
        exp_t e;
        bit got;
        @(negedge clk); auto_mem = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(posedge clk); #1; if_req = 1'b1; if_addr = 32'h500;
        @(posedge clk); #1; if_req = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); #1; mem_gnt = 1'b0; reset_n = 1'b0;
        @(negedge clk);
        n_checks++; if ({busy, mem_req} !== 2'b10) begin n_fail++; $display("FAIL midrst_wait: got busy/req=%b expected 10", {busy, mem_req}); end
        @(posedge clk); #1; reset_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        n_checks++; if ({busy, if_rvalid, dm_rvalid} !== 3'b000) begin n_fail++; $display("FAIL midrst_after: got %b expected 000", {busy, if_rvalid, dm_rvalid}); end
        @(posedge clk); #1; mem_rvalid = 1'b0; mem_rdata = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if ({busy, if_rvalid, dm_rvalid, if_rdata, dm_rdata} !== 67'h0) begin
                n_fail++; $display("FAIL midrst_quiet[%0d]: got busy=%b ifv=%b dmv=%b expected 0 0 0", c, busy, if_rvalid, dm_rvalid); end
        end
        @(posedge clk); #1; auto_mem = 1'b1; if_req = 1'b1; if_addr = 32'h504;
        @(negedge clk);
        n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_next_ready: got %b expected 1", if_ready); end
        sb_q.push_back('{dm: 1'b0, data: model_rd(32'h504)});
        @(posedge clk); #1; if_req = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin @(negedge clk); if (if_rvalid || dm_rvalid) begin got = 1'b1; break; end end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL midrst_next_resp: no rvalid within 10 cycles"); end
        else if (sb_q.size() == 0) begin n_fail++; $display("FAIL midrst_sb: scoreboard empty"); end
        else begin
            e = sb_q.pop_front();
            if (if_rvalid !== 1'b1 || dm_rvalid !== 1'b0 || if_rdata !== e.data) begin
                n_fail++; $display("FAIL midrst_next_resp: got ifv=%b data=%h expected 1 %h", if_rvalid, if_rdata, e.data); end
        end
    endtask

    task automatic test_idle_rvalid();
        @(negedge clk); auto_mem = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(posedge clk); #1; mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'h7777_7777;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if ({busy, mem_req, if_ready, dm_ready, if_rvalid, dm_rvalid, if_rdata, dm_rdata} !== 70'h0) begin
                n_fail++; $display("FAIL idle_rvalid_ctl[%0d]: got busy=%b req=%b ifv=%b dmv=%b expected all 0", c, busy, mem_req, if_rvalid, dm_rvalid); end
            n_checks++; if ({mem_addr, mem_be, mem_we} !== {32'h504, 4'hF, 1'b0}) begin
                n_fail++; $display("FAIL idle_rvalid_regs[%0d]: got addr=%h be=%h we=%b expected 00000504 f 0", c, mem_addr, mem_be, mem_we); end
            @(posedge clk); #1; mem_rvalid = 1'b0; mem_gnt = 1'b0; mem_rdata = '0;
        end
    endtask

    task automatic test_streak();
        exp_t e;
        bit   exp_dm [10];
        int   grants = 0;
        for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_dm[i] = ((i % 5) != 4);
`else
            exp_dm[i] = 1'b1;
`endif
        end
        auto_mem = 1'b1; gnt_delay = 0;
        @(posedge clk); #1; if_req = 1'b1; if_addr = 32'h700; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h600; dm_be = 4'hF;
        for (int c = 0; c < 200 && (grants < 10 || sb_q.size() > 0); c++) begin
            @(negedge clk);
            if (if_rvalid || dm_rvalid) begin
                n_checks++;
                if (sb_q.size() == 0) begin n_fail++; $display("FAIL streak_sb: rvalid with scoreboard empty"); end
                else begin
                    e = sb_q.pop_front();
                    if (dm_rvalid !== e.dm || (if_rvalid && dm_rvalid) || (e.dm ? dm_rdata : if_rdata) !== e.data) begin
                        n_fail++; $display("FAIL streak_resp: got dmv=%b ifv=%b expected dm=%b data=%h", dm_rvalid, if_rvalid, e.dm, e.data); end
                end
            end
            if ((if_ready || dm_ready) && grants < 10) begin
                n_checks++; if ({dm_ready, if_ready} !== {exp_dm[grants], !exp_dm[grants]}) begin
                    n_fail++; $display("FAIL streak_grant[%0d]: got dm/if=%b expected %b", grants, {dm_ready, if_ready}, {exp_dm[grants], !exp_dm[grants]}); end
                sb_q.push_back('{dm: dm_ready, data: model_rd(dm_ready ? 32'h600 : 32'h700)});
                grants++;
                if (grants == 10) begin @(posedge clk); #1; if_req = 1'b0; dm_req = 1'b0; end
            end
        end
        n_checks++; if (grants != 10 || sb_q.size() != 0) begin
            n_fail++; $display("FAIL streak_count: got %0d grants, %0d pending expected 10 grants, 0 pending", grants, sb_q.size()); end
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_fetch();
        test_priority();
        test_gnt_stall();
        test_reset_midflight();
        test_idle_rvalid();
        test_streak();
        n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
